// File: rtl/lvds_pll_reconfig_ctrl_pkg.sv
// Shared definitions for the LVDS PLL reconfiguration controller.
// Holds the state encoding, the per-mode divider table and the mode-count limit.
package lvds_pll_reconfig_ctrl_pkg;

    localparam int MAX_MODES = 8;

    typedef enum logic [1:0] {
        ST_RST_PULSE = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_ERROR     = 2'd3
    } pll_state_e;

    typedef struct packed {
        logic [5:0] fbdsel;
        logic [5:0] idsel;
        logic [5:0] odsel;
    } mode_cfg_t;

    // Codes are already in the PLL dynamic-select encoding; they go to the pins unchanged.
    function automatic mode_cfg_t mode_cfg(input logic [2:0] mode);
        mode_cfg_t cfg;
        cfg = '0;
        case (mode)
            3'd0: cfg = '{fbdsel: 6'h13, idsel: 6'h01, odsel: 6'h02};
            3'd1: cfg = '{fbdsel: 6'h1B, idsel: 6'h01, odsel: 6'h03};
            3'd2: cfg = '{fbdsel: 6'h27, idsel: 6'h02, odsel: 6'h04};
            3'd3: cfg = '{fbdsel: 6'h0F, idsel: 6'h00, odsel: 6'h01};
            3'd4: cfg = '{fbdsel: 6'h21, idsel: 6'h03, odsel: 6'h02};
            3'd5: cfg = '{fbdsel: 6'h17, idsel: 6'h01, odsel: 6'h05};
            3'd6: cfg = '{fbdsel: 6'h2D, idsel: 6'h04, odsel: 6'h03};
            3'd7: cfg = '{fbdsel: 6'h09, idsel: 6'h00, odsel: 6'h06};
        endcase
        return cfg;
    endfunction

    // Width of a counter that must hold values 0..n (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lvds_pll_reconfig_ctrl_lock_filter.sv
// Two-flop synchroniser for the raw PLL lock plus a consecutive-high filter
// that only counts while enabled and restarts on any low synchronised sample.
module lvds_pll_lock_filter
    import lvds_pll_reconfig_ctrl_pkg::*;
#(
    parameter int LOCK_FILTER_CYCLES = 64
) (
    input  logic clkin,
    input  logic reset,
    input  logic enable,
    input  logic pll_lock,
    output logic lock_sync,
    output logic lock_ok
);

    localparam int CW = cnt_width(LOCK_FILTER_CYCLES);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= pll_lock;
            sync2_reg <= sync1_reg;
            if (!enable || !sync2_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CW'(LOCK_FILTER_CYCLES)) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign lock_sync = sync2_reg;
    assign lock_ok   = (cnt_reg == CW'(LOCK_FILTER_CYCLES));

endmodule

// File: rtl/lvds_pll_reconfig_ctrl.sv
// LVDS PLL reconfiguration controller: loads divider selects, pulses the PLL
// reset, waits for filtered lock with timeout/retry. Optional build macro
// LVDS_PLL_LOCK_LOSS_RECOVER_EN re-runs the sequence when lock drops while LOCKED.
module lvds_pll_reconfig_ctrl
    import lvds_pll_reconfig_ctrl_pkg::*;
#(
    parameter int NUM_MODES          = 4,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int LOCK_FILTER_CYCLES = 64,
    parameter int TIMEOUT_CYCLES     = 65536,
    parameter int MAX_RETRY          = 3
) (
    input  logic                         clkin,
    input  logic                         reset,
    input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
    input  logic                         mode_req,
    input  logic                         pll_lock,
    output logic                         pll_reset,
    output logic [5:0]                   fbdsel,
    output logic [5:0]                   idsel,
    output logic [5:0]                   odsel,
    output logic                         locked,
    output logic                         busy,
    output logic                         err,
    output logic                         mode_ack,
    output logic [$clog2(NUM_MODES)-1:0] cur_mode
);

    localparam int MW = $clog2(NUM_MODES);
    localparam int PW = cnt_width(RESET_PULSE_CYCLES);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int RW = cnt_width(MAX_RETRY);

    pll_state_e    state;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] wait_cnt;
    logic [RW-1:0] retry_cnt;
    logic [MW-1:0] target_mode;
    logic [MW-1:0] pend_mode;
    logic [MW-1:0] cur_mode_reg;
    logic          pend_valid;
    mode_cfg_t     sel_reg;
    logic          pll_reset_reg, locked_reg, busy_reg, err_reg, mode_ack_reg;

    logic          lock_sync, lock_ok;
    logic          req_ok, timeout_hit, start_pulse;
    logic [MW-1:0] start_mode;

    lvds_pll_lock_filter #(
        .LOCK_FILTER_CYCLES(LOCK_FILTER_CYCLES)
    ) u_lock_filter (
        .clkin    (clkin),
        .reset    (reset),
        .enable   (state == ST_WAIT_LOCK),
        .pll_lock (pll_lock),
        .lock_sync(lock_sync),
        .lock_ok  (lock_ok)
    );

    assign req_ok      = mode_req && (32'(mode_sel) < NUM_MODES);
    assign timeout_hit = (wait_cnt >= TW'(TIMEOUT_CYCLES - 1));

    // Every path that (re)starts a reset pulse, with the mode it will program.
    always_comb begin
        start_pulse = 1'b0;
        start_mode  = target_mode;
        case (state)
            ST_WAIT_LOCK: start_pulse = !lock_ok && timeout_hit && (retry_cnt < RW'(MAX_RETRY));
            ST_LOCKED: begin
                if (req_ok) begin
                    start_pulse = 1'b1;
                    start_mode  = mode_sel;
                end else if (pend_valid) begin
                    start_pulse = 1'b1;
                    start_mode  = pend_mode;
                end
`ifdef LVDS_PLL_LOCK_LOSS_RECOVER_EN
                else if (!lock_sync) begin
                    start_pulse = 1'b1;
                    start_mode  = cur_mode_reg;
                end
`endif
            end
            ST_ERROR: begin
                if (req_ok) begin
                    start_pulse = 1'b1;
                    start_mode  = mode_sel;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state         <= ST_RST_PULSE;
            pulse_cnt     <= '0;
            wait_cnt      <= '0;
            retry_cnt     <= '0;
            target_mode   <= '0;
            pend_valid    <= 1'b0;
            pend_mode     <= '0;
            cur_mode_reg  <= '0;
            sel_reg       <= mode_cfg(3'd0);
            pll_reset_reg <= 1'b1;
            locked_reg    <= 1'b0;
            busy_reg      <= 1'b1;
            err_reg       <= 1'b0;
            mode_ack_reg  <= 1'b0;
        end else begin
            mode_ack_reg <= 1'b0;
            case (state)
                ST_RST_PULSE: begin
                    if (req_ok) begin
                        pend_valid <= 1'b1;
                        pend_mode  <= mode_sel;
                    end
                    if (pulse_cnt >= PW'(RESET_PULSE_CYCLES - 1)) begin
                        state         <= ST_WAIT_LOCK;
                        wait_cnt      <= '0;
                        pll_reset_reg <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (req_ok) begin
                        pend_valid <= 1'b1;
                        pend_mode  <= mode_sel;
                    end
                    if (lock_ok) begin
                        state        <= ST_LOCKED;
                        cur_mode_reg <= target_mode;
                        locked_reg   <= 1'b1;
                        busy_reg     <= 1'b0;
                        retry_cnt    <= '0;
                        // A waiting request supersedes this mode, so it is never acknowledged.
                        mode_ack_reg <= !(pend_valid || req_ok);
                    end else if (timeout_hit) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                        end else begin
                            state    <= ST_ERROR;
                            busy_reg <= 1'b0;
                            err_reg  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                ST_LOCKED: begin
                    locked_reg <= lock_sync;
                    if (start_pulse) begin
                        retry_cnt  <= '0;
                        pend_valid <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (start_pulse) retry_cnt <= '0;
                end
                default: state <= ST_RST_PULSE;
            endcase
            if (start_pulse) begin
                state         <= ST_RST_PULSE;
                pulse_cnt     <= '0;
                target_mode   <= start_mode;
                sel_reg       <= mode_cfg(3'(start_mode));
                pll_reset_reg <= 1'b1;
                busy_reg      <= 1'b1;
                locked_reg    <= 1'b0;
                err_reg       <= 1'b0;
            end
        end
    end

    assign pll_reset = pll_reset_reg;
    assign fbdsel    = sel_reg.fbdsel;
    assign idsel     = sel_reg.idsel;
    assign odsel     = sel_reg.odsel;
    assign locked    = locked_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;
    assign mode_ack  = mode_ack_reg;
    assign cur_mode  = cur_mode_reg;

endmodule

// File: tb/tb_lvds_pll_reconfig_ctrl.sv
// Bench for lvds_pll_reconfig_ctrl: directed stimulus, expected pulses/acks queued
// and checked by an independent monitor; timing checks inline.
module tb_lvds_pll_reconfig_ctrl;

    localparam int RPC = 4;
    localparam int LFC = 8;
    localparam int TO  = 100;
    localparam int MR  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_req = 1'b0;
    logic       pll_lock = 1'b1;
    logic [1:0] mode_sel = 2'd0;
    logic       pll_reset, locked, busy, err, mode_ack;
    logic [5:0] fbdsel, idsel, odsel;
    logic [1:0] cur_mode;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] pulse_q[$];
    int          ack_q[$];

    lvds_pll_reconfig_ctrl #(
        .NUM_MODES         (4),
        .RESET_PULSE_CYCLES(RPC),
        .LOCK_FILTER_CYCLES(LFC),
        .TIMEOUT_CYCLES    (TO),
        .MAX_RETRY         (MR)
    ) dut (
        .clkin    (clk),
        .reset    (reset),
        .mode_sel (mode_sel),
        .mode_req (mode_req),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .fbdsel   (fbdsel),
        .idsel    (idsel),
        .odsel    (odsel),
        .locked   (locked),
        .busy     (busy),
        .err      (err),
        .mode_ack (mode_ack),
        .cur_mode (cur_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] exp_sel(input int m);
        case (m)
            0: return {6'h13, 6'h01, 6'h02};
            1: return {6'h1B, 6'h01, 6'h03};
            2: return {6'h27, 6'h02, 6'h04};
            3: return {6'h0F, 6'h00, 6'h01};
            default: return 18'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called on a falling edge; the request is seen by exactly one rising edge.
    task automatic request(input int m);
        mode_sel = 2'(m);
        mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
    endtask

    // Sample index 0 is the current falling edge; returns the first index with locked=1.
    task automatic wait_lock(input int bound, output int idx, output int highs);
        idx = -1;
        highs = 0;
        for (int k = 0; k <= bound; k++) begin
            if (k > 0) @(negedge clk);
            if (pll_reset) highs++;
            if (locked) begin
                idx = k;
                break;
            end
        end
        if (idx < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL lock_timeout: locked still 0 after %0d cycles, expected 1", bound);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({tag, "_busy"},      32'(busy),      32'd1);
        check({tag, "_locked"},    32'(locked),    32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_mode_ack"},  32'(mode_ack),  32'd0);
        check({tag, "_cur_mode"},  32'(cur_mode),  32'd0);
        check({tag, "_selects"},   32'({fbdsel, idsel, odsel}), 32'(exp_sel(0)));
    endtask

    // Monitor: every pll_reset rise must carry the queued selects, every ack the queued mode.
    initial begin
        logic prev_rst;
        logic [17:0] es;
        int em;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (pll_reset === 1'b1 && !prev_rst) begin
                if (pulse_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pulse_sel: unexpected pll_reset pulse with selects 0x%0h, expected none", {fbdsel, idsel, odsel});
                end else begin
                    es = pulse_q.pop_front();
                    check("pulse_sel", 32'({fbdsel, idsel, odsel}), 32'(es));
                end
            end
            prev_rst = (pll_reset === 1'b1);
            if (mode_ack === 1'b1) begin
                if (ack_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack_mode: unexpected mode_ack for cur_mode %0d, expected none", cur_mode);
                end else begin
                    em = ack_q.pop_front();
                    check("ack_mode", 32'(cur_mode), 32'(em));
                    check("ack_locked", 32'(locked), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, highs, rises, r0, r1, erri;
        logic prev, seen;

        // Reset and initial bring-up of mode 0.
        pulse_q.push_back(exp_sel(0));
        ack_q.push_back(0);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        wait_lock(40, idx, highs);
        check("init_pulse_len", 32'(highs), 32'(RPC));
        check_range("init_lock_latency", idx, RPC + LFC + 1, RPC + LFC + 3);
        check("init_cur_mode", 32'(cur_mode), 32'd0);

        // Reconfigure to mode 2 from LOCKED.
        @(negedge clk);
        pulse_q.push_back(exp_sel(2));
        ack_q.push_back(2);
        request(2);
        wait_lock(60, idx, highs);
        check("mode2_pulse_len", 32'(highs), 32'(RPC));
        check("mode2_lock_latency", 32'(idx), 32'(RPC + LFC + 1));
        check("mode2_cur_mode", 32'(cur_mode), 32'd2);

        // Lock never arrives: initial pulse plus MR retries, then error.
        @(negedge clk);
        repeat (MR + 1) pulse_q.push_back(exp_sel(1));
        pll_lock = 1'b0;
        request(1);
        rises = 0; r0 = -1; r1 = -1; erri = -1; prev = 1'b0;
        for (int k = 0; k <= 400; k++) begin
            if (k > 0) @(negedge clk);
            if (pll_reset && !prev) begin
                if (rises == 0) r0 = k;
                else if (rises == 1) r1 = k;
                rises++;
            end
            prev = pll_reset;
            if (err) begin
                erri = k;
                break;
            end
        end
        check("timeout_pulses", 32'(rises), 32'(MR + 1));
        check("timeout_spacing", 32'(r1 - r0), 32'(RPC + TO));
        check("timeout_err_time", 32'(erri), 32'((MR + 1) * (RPC + TO)));
        check("error_busy", 32'(busy), 32'd0);
        check("error_locked", 32'(locked), 32'd0);

        // Recovery from ERROR with a new request.
        @(negedge clk);
        pll_lock = 1'b1;
        pulse_q.push_back(exp_sel(0));
        ack_q.push_back(0);
        request(0);
        wait_lock(60, idx, highs);
        check("recover_cur_mode", 32'(cur_mode), 32'd0);
        check("recover_err", 32'(err), 32'd0);

        // Lock glitching low every 5 cycles blocks the filter; clean high locks.
        @(negedge clk);
        pulse_q.push_back(exp_sel(3));
        ack_q.push_back(3);
        request(3);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pll_lock = ((i % 5) != 4);
            if (locked) seen = 1'b1;
            @(negedge clk);
        end
        pll_lock = 1'b1;
        wait_lock(40, idx, highs);
        check("glitch_no_lock", 32'(seen), 32'd0);
        check("clean_lock_latency", 32'(idx), 32'(2 + LFC + 1));
        check("glitch_cur_mode", 32'(cur_mode), 32'd3);

        // Two requests while busy: only the last (mode 3) is serviced and acked.
        @(negedge clk);
        pulse_q.push_back(exp_sel(2));
        request(2);
        mode_sel = 2'd1;
        mode_req = 1'b1;
        @(negedge clk);
        mode_sel = 2'd3;
        @(negedge clk);
        mode_req = 1'b0;
        pulse_q.push_back(exp_sel(3));
        ack_q.push_back(3);
        wait_lock(60, idx, highs);
        check("brief_lock_mode", 32'(cur_mode), 32'd2);
        check("brief_lock_ack", 32'(mode_ack), 32'd0);
        @(negedge clk);
        wait_lock(60, idx, highs);
        check("pending_pulse_len", 32'(highs), 32'(RPC));
        check("pending_cur_mode", 32'(cur_mode), 32'd3);

        // Lock drop while LOCKED.
        @(negedge clk);
        rises = 0; seen = 1'b0; prev = pll_reset;
`ifdef LVDS_PLL_LOCK_LOSS_RECOVER_EN
        pulse_q.push_back(exp_sel(3));
        ack_q.push_back(3);
`endif
        pll_lock = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!locked) seen = 1'b1;
            if (pll_reset && !prev) rises++;
            prev = pll_reset;
        end
        pll_lock = 1'b1;
        check("loss_locked_low", 32'(seen), 32'd1);
`ifdef LVDS_PLL_LOCK_LOSS_RECOVER_EN
        check("loss_pulses", 32'(rises), 32'd1);
        wait_lock(60, idx, highs);
        check("loss_cur_mode", 32'(cur_mode), 32'd3);
`else
        check("loss_pulses", 32'(rises), 32'd0);
        check("loss_busy", 32'(busy), 32'd0);
        idx = -1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (locked) begin
                idx = k;
                break;
            end
        end
        check("loss_relock_latency", 32'(idx), 32'd3);
        check("loss_cur_mode", 32'(cur_mode), 32'd3);
`endif

        // Reset in the middle of a reconfiguration restarts from mode 0.
        @(negedge clk);
        pulse_q.push_back(exp_sel(2));
        request(2);
        repeat (5) @(negedge clk);
        pulse_q.push_back(exp_sel(0));
        ack_q.push_back(0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        wait_lock(40, idx, highs);
        check("midreset_pulse_len", 32'(highs), 32'(RPC));
        check_range("midreset_lock_latency", idx, RPC + LFC + 1, RPC + LFC + 3);
        check("midreset_cur_mode", 32'(cur_mode), 32'd0);

        repeat (3) @(negedge clk);
        check("pulse_q_drained", 32'(pulse_q.size()), 32'd0);
        check("ack_q_drained", 32'(ack_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
